// File: rtl/Structures.sv
// Shared types for the stream register writer.
//   UART_PACKET : one byte of the receive stream plus its framing sideband
//   srw_state_t : controller states
//
// state | meaning
// IDLE  | waiting for a start-of-packet byte
// ADDR  | collecting the remaining address bytes (MS first)
// DATA  | collecting the bytes of a word (MS first)
// WRITE | word assembled, write request held until the register file accepts it
// DROP  | packet for another destination, consuming bytes up to EoP
package Structures;

  typedef struct packed {
    logic       Valid;
    logic       SoP;
    logic       EoP;
    logic [7:0] Source;
    logic [7:0] Destination;
    logic [7:0] Length;
    logic [7:0] Data;
  } UART_PACKET;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    DROP  = 3'd4
  } srw_state_t;

endpackage

// File: rtl/stream_reg_writer.sv
// Converts a framed byte stream into register writes. Each packet carries an
// address followed by any number of whole data words; words are written at
// consecutive addresses (or a fixed address when AUTO_INC is 0).
//
// Ports:
//   ipClk, ipReset  : clock and synchronous active-high reset
//   ipRxStream      : input byte stream (Valid/SoP/EoP/Destination/Data used)
//   opRxReady       : stream ready, low while a write is pending
//   opAddress       : register address
//   opWrData        : register write data
//   opWrEnable      : write request, completes when ipWrReady is high
//   ipWrReady       : register-file back-pressure
//   opWordCount     : completed writes, wrapping
//   opErrorCount    : framing errors, saturating
module stream_reg_writer
  import Structures::*;
#(
  parameter int         DATA_BYTES = 4,
  parameter int         ADDR_BYTES = 1,
  parameter logic [7:0] LOCAL_ID   = 8'h01,
  parameter bit         AUTO_INC   = 1'b1
) (
  input  logic                    ipClk,
  input  logic                    ipReset,
  input  UART_PACKET              ipRxStream,
  output logic                    opRxReady,
  output logic [8*ADDR_BYTES-1:0] opAddress,
  output logic [8*DATA_BYTES-1:0] opWrData,
  output logic                    opWrEnable,
  input  logic                    ipWrReady,
  output logic [15:0]             opWordCount,
  output logic [7:0]              opErrorCount
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;
  localparam logic [2:0] ADDR_LAST = 3'(ADDR_BYTES - 1);
  localparam logic [2:0] DATA_LAST = 3'(DATA_BYTES - 1);

  srw_state_t      state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            eop_q, eop_d;
  logic [15:0]     word_cnt_q, word_cnt_d;
  logic [7:0]      err_cnt_q, err_cnt_d;

  logic       rx_fire;
  logic       rx_sop;
  logic       rx_eop;
  logic       rx_local;
  logic [7:0] rx_byte;
  logic       start_pkt;
  logic       err_inc;

  // Source and Length play no part in framing.
  logic unused_fields;
  assign unused_fields = ^{ipRxStream.Source, ipRxStream.Length};

  assign opRxReady  = !ipReset && (state_q != WRITE);
  assign opWrEnable = !ipReset && (state_q == WRITE);

  assign rx_fire  = ipRxStream.Valid && opRxReady;
  assign rx_sop   = ipRxStream.SoP;
  assign rx_eop   = ipRxStream.EoP;
  assign rx_byte  = ipRxStream.Data;
  assign rx_local = (ipRxStream.Destination == LOCAL_ID);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    eop_d      = eop_q;
    word_cnt_d = word_cnt_q;
    err_cnt_d  = err_cnt_q;
    start_pkt  = 1'b0;
    err_inc    = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_fire) begin
          if (rx_sop) start_pkt = 1'b1;
          else        err_inc   = 1'b1;
        end
      end

      ADDR: begin
        if (rx_fire) begin
          if (rx_sop) begin
            err_inc   = 1'b1;
            start_pkt = 1'b1;
          end else begin
            addr_d = AW'({addr_q, rx_byte});
            if (cnt_q == ADDR_LAST) begin
              // EoP on the final address byte is a legal address-only packet.
              cnt_d   = 3'd0;
              state_d = rx_eop ? IDLE : DATA;
            end else if (rx_eop) begin
              err_inc = 1'b1;
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
      end

      DATA: begin
        if (rx_fire) begin
          if (rx_sop) begin
            err_inc   = 1'b1;
            start_pkt = 1'b1;
          end else begin
            data_d = DW'({data_q, rx_byte});
            if (cnt_q == DATA_LAST) begin
              cnt_d   = 3'd0;
              eop_d   = rx_eop;
              state_d = WRITE;
            end else if (rx_eop) begin
              err_inc = 1'b1;
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
      end

      WRITE: begin
        if (ipWrReady) begin
          word_cnt_d = word_cnt_q + 16'd1;
          if (AUTO_INC) addr_d = addr_q + AW'(1);
          state_d = eop_q ? IDLE : DATA;
        end
      end

      DROP: begin
        if (rx_fire && rx_eop) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // A start byte, whether in IDLE or aborting a packet, begins a new packet.
    if (start_pkt) begin
      cnt_d = 3'd0;
      if (rx_local) begin
        addr_d = AW'(rx_byte);
        if (ADDR_BYTES == 1) begin
          state_d = rx_eop ? IDLE : DATA;
        end else if (rx_eop) begin
          err_inc = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d   = 3'd1;
          state_d = ADDR;
        end
      end else begin
        state_d = rx_eop ? IDLE : DROP;
      end
    end

    if (err_inc && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      eop_q      <= 1'b0;
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      eop_q      <= eop_d;
      word_cnt_q <= word_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign opAddress    = addr_q;
  assign opWrData     = data_q;
  assign opWordCount  = word_cnt_q;
  assign opErrorCount = err_cnt_q;

endmodule

// File: tb/tb_stream_reg_writer.sv
module tb_stream_reg_writer;
  import Structures::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  UART_PACKET  rx_a, rx_b;
  logic        rdy_a, rdy_b, we_a, we_b;
  logic        wr_ready_a;
  logic [7:0]  addr_a, addr_b, ec_a, ec_b;
  logic [31:0] wd_a, wd_b;
  logic [15:0] wc_a, wc_b;

  stream_reg_writer u_dut (
    .ipClk(clk), .ipReset(rst), .ipRxStream(rx_a), .opRxReady(rdy_a),
    .opAddress(addr_a), .opWrData(wd_a), .opWrEnable(we_a), .ipWrReady(wr_ready_a),
    .opWordCount(wc_a), .opErrorCount(ec_a)
  );

  stream_reg_writer #(.AUTO_INC(1'b0)) u_fixed (
    .ipClk(clk), .ipReset(rst), .ipRxStream(rx_b), .opRxReady(rdy_b),
    .opAddress(addr_b), .opWrData(wd_b), .opWrEnable(we_b), .ipWrReady(1'b1),
    .opWordCount(wc_b), .opErrorCount(ec_b)
  );

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_a[$];
  wr_t exp_b[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  exp_words = 0, exp_errs = 0, exp_words_b = 0;

  bit  rand_ready   = 1'b0;
  bit  forced_ready = 1'b1;
  bit  watch_ready  = 1'b0;
  int  ready_low    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a local packet is an address byte followed by whole
  // 4-byte words; any leftover bytes, or a packet cut short by a new start,
  // count as one framing error.
  function automatic void model_pkt(input logic [7:0] dest, input logic [7:0] bytes[$],
                                    input bit by_eop, input bit to_b);
    logic [7:0] a;
    int n, nw;
    if (dest != 8'h01) return;
    n  = bytes.size();
    nw = (n - 1) / 4;
    a  = bytes[0];
    for (int w = 0; w < nw; w++) begin
      wr_t e;
      e.a = a;
      e.d = {bytes[1+4*w], bytes[2+4*w], bytes[3+4*w], bytes[4+4*w]};
      if (to_b) begin
        exp_b.push_back(e);
        exp_words_b++;
      end else begin
        exp_a.push_back(e);
        exp_words++;
        a = a + 8'd1;
      end
    end
    if (!to_b && (!by_eop || ((n - 1) % 4 != 0)) && exp_errs < 255) exp_errs++;
  endfunction

  always @(posedge clk) begin
    #1;
    wr_ready_a = rand_ready ? ($urandom_range(0, 3) != 0) : forced_ready;
  end

  always @(negedge clk) if (watch_ready && !rdy_a) ready_low++;

  // Monitor for the auto-increment instance.
  bit          stalled = 1'b0;
  logic [7:0]  hold_a;
  logic [31:0] hold_d;
  always @(negedge clk) begin
    if (we_a) begin
      check("rx_ready_low_in_write", {63'd0, rdy_a}, 64'd0);
      if (stalled) begin
        check("addr_stable", 64'(addr_a), 64'(hold_a));
        check("data_stable", 64'(wd_a), 64'(hold_d));
      end
      stalled = !wr_ready_a;
      hold_a  = addr_a;
      hold_d  = wd_a;
      if (wr_ready_a) begin
        if (exp_a.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write_a: addr %0h data %0h", addr_a, wd_a);
        end else begin
          wr_t e;
          e = exp_a.pop_front();
          check("write_addr", 64'(addr_a), 64'(e.a));
          check("write_data", 64'(wd_a), 64'(e.d));
        end
      end
    end else begin
      stalled = 1'b0;
    end
  end

  // Monitor for the fixed-address instance.
  always @(negedge clk) begin
    if (we_b) begin
      if (exp_b.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write_b: addr %0h data %0h", addr_b, wd_b);
      end else begin
        wr_t e;
        e = exp_b.pop_front();
        check("fixed_addr", 64'(addr_b), 64'(e.a));
        check("fixed_data", 64'(wd_b), 64'(e.d));
      end
    end
  end

  task automatic send_byte(input bit which, input logic sop, input logic eop,
                           input logic [7:0] dest, input logic [7:0] data);
    UART_PACKET p;
    int t;
    p.Valid = 1'b1; p.SoP = sop; p.EoP = eop; p.Source = 8'h00;
    p.Destination = dest; p.Length = 8'($urandom_range(0, 255)); p.Data = data;
    if (which) rx_b = p; else rx_a = p;
    t = 0;
    forever begin
      @(negedge clk);
      if (which ? rdy_b : rdy_a) break;
      t++;
      if (t > 2000) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: ready stuck low, required high");
        break;
      end
    end
    @(posedge clk);
    #1;
    if (which) rx_b = '0; else rx_a = '0;
  endtask

  task automatic send_pkt(input bit which, input logic [7:0] dest, input logic [7:0] bytes[$],
                          input bit by_eop, input bit gaps);
    model_pkt(dest, bytes, by_eop, which);
    for (int i = 0; i < bytes.size(); i++) begin
      send_byte(which, i == 0, by_eop && (i == bytes.size() - 1), dest, bytes[i]);
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0 || we_a || we_b) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d writes outstanding, required 0", exp_a.size() + exp_b.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag);
    @(negedge clk);
    check({tag, "_word_count"}, 64'(wc_a), 64'(16'(exp_words)));
    check({tag, "_error_count"}, 64'(ec_a), 64'(exp_errs));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_we();
    int t = 0;
    while (!we_a && t < 200) begin @(negedge clk); t++; end
    if (!we_a) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_write_timeout: opWrEnable 0, required 1");
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_rx_ready"}, {63'd0, rdy_a}, 64'd0);
    check({tag, "_wr_enable"}, {63'd0, we_a}, 64'd0);
    check({tag, "_address"}, 64'(addr_a), 64'd0);
    check({tag, "_wr_data"}, 64'(wd_a), 64'd0);
    check({tag, "_word_count"}, 64'(wc_a), 64'd0);
    check({tag, "_error_count"}, 64'(ec_a), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] q32[$];
    logic [7:0] pk[$];
    bit must_start;
    q32 = '{8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};

    rst = 1'b1;
    rx_a = '0;
    rx_b = '0;
    repeat (3) @(posedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {63'd0, rdy_a}, 64'd1);
    @(posedge clk);
    #1;

    // Basic two-word packet.
    send_pkt(0, 8'h01, q32, 1, 0);
    drain();
    check_counts("basic");

    // Same packet with the register file stalled during the first write.
    forced_ready = 1'b0;
    @(posedge clk);
    #2;
    fork
      send_pkt(0, 8'h01, q32, 1, 0);
      begin
        wait_we();
        repeat (5) @(posedge clk);
        forced_ready = 1'b1;
      end
    join
    drain();
    check_counts("stall");

    // Foreign packet is dropped with the stream never stalled.
    pk = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    ready_low   = 0;
    watch_ready = 1'b1;
    send_pkt(0, 8'h02, pk, 1, 0);
    watch_ready = 1'b0;
    check("foreign_ready_low_cycles", 64'(ready_low), 64'd0);
    drain();
    check_counts("foreign");

    // Truncated word, then a good packet.
    pk = '{8'h20, 8'hAA, 8'hBB};
    send_pkt(0, 8'h01, pk, 1, 0);
    drain();
    check_counts("truncated");
    pk = '{8'h30, 8'h12, 8'h34, 8'h56, 8'h78};
    send_pkt(0, 8'h01, pk, 1, 0);
    drain();
    check_counts("after_truncated");

    // Address wrap versus fixed address.
    pk = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
    send_pkt(0, 8'h01, pk, 1, 0);
    send_pkt(1, 8'h01, pk, 1, 0);
    drain();
    check_counts("wrap");
    @(negedge clk);
    check("fixed_word_count", 64'(wc_b), 64'(exp_words_b));
    @(posedge clk);
    #1;

    // Reset while a write is pending.
    forced_ready = 1'b0;
    @(posedge clk);
    #2;
    pk = '{8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_pkt(0, 8'h01, pk, 1, 0);
    wait_we();
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_a.delete();
    exp_b.delete();
    exp_words = 0; exp_errs = 0; exp_words_b = 0;
    @(posedge clk);
    #1;
    check_reset_outputs("midwrite_reset");
    forced_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_midwrite_reset", {63'd0, rdy_a}, 64'd1);
    @(posedge clk);
    #1;
    send_pkt(0, 8'h01, q32, 1, 0);
    drain();
    check_counts("post_reset");

    // Randomized traffic with random back-pressure.
    rand_ready = 1'b1;
    must_start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      int kind, len;
      kind = (k == 39) ? 0 : int'($urandom_range(0, 4));
      if (must_start && kind == 3) kind = 0;
      pk.delete();
      case (kind)
        0: len = 1 + 4 * int'($urandom_range(0, 3));
        1: len = int'($urandom_range(1, 10));
        2: len = 1 + 4 * int'($urandom_range(0, 2)) + int'($urandom_range(1, 3));
        3: len = 1;
        default: len = int'($urandom_range(1, 9));
      endcase
      for (int i = 0; i < len; i++) pk.push_back(8'($urandom_range(0, 255)));
      if (kind == 3) begin
        if (exp_errs < 255) exp_errs++;
        send_byte(0, 1'b0, 1'b0, 8'h01, pk[0]);
      end else begin
        send_pkt(0, (kind == 1) ? 8'($urandom_range(2, 255)) : 8'h01, pk, kind != 4, 1);
      end
      must_start = (kind == 4);
    end
    rand_ready = 1'b0;
    drain();
    check_counts("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
